float64_mul_arbiter: RTL and testbench

//   Round-robin scheduler that shares one float64_mul core (ap_start/ap_done/ap_ready

---
 rtl/float64_mul_arbiter_pkg.sv | 17 +
 rtl/float64_mul_arbiter_if.sv | 37 +++
 rtl/float64_mul_arbiter_rr_pick.sv | 34 +++
 rtl/float64_mul_arbiter.sv | 118 +++++++++++
 tb/tb_float64_mul_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/float64_mul_arbiter_pkg.sv
// Shared types and defaults for the float64_mul round-robin arbiter.
// The FSM state encoding is one-hot so that each state flop is directly an output decode.
package float64_mul_arbiter_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned DW_DEF   = 64;
    localparam int unsigned CNTW_DEF = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_RESP  = 4'b1000
    } state_e;

endpackage

// File: rtl/float64_mul_arbiter_if.sv
// Requester, core and status signals of the float64_mul arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface float64_mul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 64,
    parameter int unsigned CNTW = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;
    logic               mul_ap_start;
    logic [DW-1:0]      mul_a;
    logic [DW-1:0]      mul_b;
    logic               mul_ap_ready;
    logic               mul_ap_done;
    logic [DW-1:0]      mul_ap_return;
    logic               busy;
    logic [CNTW-1:0]    ops_count;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready,
        input  mul_ap_ready, mul_ap_done, mul_ap_return,
        output req_ready, rsp_valid, rsp_data,
        output mul_ap_start, mul_a, mul_b, busy, ops_count
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready,
        output mul_ap_ready, mul_ap_done, mul_ap_return,
        input  req_ready, rsp_valid, rsp_data,
        input  mul_ap_start, mul_a, mul_b, busy, ops_count
    );
endinterface

// File: rtl/float64_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping mod NREQ.
// The last-granted requester is scanned last, so it wins only if nobody else asks.
module float64_mul_arbiter_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    int unsigned w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_pos = 32'(i_last) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!o_any && i_req[IDXW'(w_pos)]) begin
                o_any                 = 1'b1;
                o_idx                 = IDXW'(w_pos);
                o_grant[IDXW'(w_pos)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float64_mul_arbiter.sv
// Shares one float64_mul core among NREQ requesters with round-robin arbitration.
// One operation in flight: accept, start the core, wait for done, hand back the product.
module float64_mul_arbiter
    import float64_mul_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic ap_clk,
    input  logic ap_rst,
    float64_mul_arbiter_if.master bus
);

    localparam int unsigned IDXW = $clog2(NREQ);

    state_e          r_state;
    logic [IDXW-1:0] r_last;
    logic [IDXW-1:0] r_grant;
    logic [NREQ-1:0] r_grant_oh;
    logic [DW-1:0]   r_mul_a;
    logic [DW-1:0]   r_mul_b;
    logic [DW-1:0]   r_result;
    logic [CNTW-1:0] r_ops;

    logic [NREQ-1:0] w_pick_oh;
    logic [IDXW-1:0] w_pick_idx;
    logic            w_pick_any;
    logic [DW-1:0]   w_sel_a;
    logic [DW-1:0]   w_sel_b;
    logic            w_rsp_take;

    float64_mul_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_last),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Operand mux for the requester the picker selected this cycle.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_pick_idx == IDXW'(i)) begin
                w_sel_a = bus.req_a[i*DW +: DW];
                w_sel_b = bus.req_b[i*DW +: DW];
            end
        end
    end

    // Only the granted requester's rsp_ready completes a response.
    assign w_rsp_take = |(bus.rsp_ready & r_grant_oh);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= ST_IDLE;
            r_last     <= IDXW'(NREQ - 1);
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_result   <= '0;
            r_ops      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_mul_a    <= w_sel_a;
                        r_mul_b    <= w_sel_b;
                        r_grant    <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bus.mul_ap_ready) begin
                        if (bus.mul_ap_done) begin
                            r_result <= bus.mul_ap_return;
                            r_state  <= ST_RESP;
                        end else begin
                            r_state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.mul_ap_done) begin
                        r_result <= bus.mul_ap_return;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_take) begin
                        r_last  <= r_grant;
                        r_ops   <= r_ops + CNTW'(1);
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Accept pulse is combinational so a requester is acknowledged in the cycle it is picked.
    assign bus.req_ready    = (r_state == ST_IDLE) ? w_pick_oh : '0;
    assign bus.rsp_valid    = (r_state == ST_RESP) ? r_grant_oh : '0;
    assign bus.rsp_data     = r_result;
    assign bus.mul_ap_start = (r_state == ST_START);
    assign bus.mul_a        = r_mul_a;
    assign bus.mul_b        = r_mul_b;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.ops_count    = r_ops;

endmodule

// File: tb/tb_float64_mul_arbiter.sv
// Directed bench for float64_mul_arbiter with a simple latency-configurable core model.
module tb_float64_mul_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 64;
    localparam int unsigned CNTW = 32;

    localparam logic [63:0] F_M1  = 64'hBFF0000000000000;
    localparam logic [63:0] F_1   = 64'h3FF0000000000000;
    localparam logic [63:0] F_1P5 = 64'h3FF8000000000000;
    localparam logic [63:0] F_2   = 64'h4000000000000000;
    localparam logic [63:0] F_M2  = 64'hC000000000000000;
    localparam logic [63:0] F_3   = 64'h4008000000000000;
    localparam logic [63:0] F_6   = 64'h4018000000000000;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   core_lat;

    float64_mul_arbiter_if #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) bus ();

    float64_mul_arbiter #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: ap_ready with start; done after core_lat cycles (0 = same cycle).
    initial begin : core_model
        int          cnt;
        bit          pending;
        logic [63:0] held;
        cnt = 0;
        pending = 1'b0;
        held = '0;
        bus.mul_ap_ready  = 1'b0;
        bus.mul_ap_done   = 1'b0;
        bus.mul_ap_return = '0;
        forever begin
            @(negedge clk);
            bus.mul_ap_ready = 1'b0;
            bus.mul_ap_done  = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    bus.mul_ap_done   = 1'b1;
                    bus.mul_ap_return = held;
                    pending = 1'b0;
                end
            end else if (bus.mul_ap_start) begin
                bus.mul_ap_ready = 1'b1;
                held = $realtobits($bitstoreal(bus.mul_a) * $bitstoreal(bus.mul_b));
                if (core_lat == 0) begin
                    bus.mul_ap_done   = 1'b1;
                    bus.mul_ap_return = held;
                end else begin
                    pending = 1'b1;
                    cnt = core_lat;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_ops(input int r, input logic [63:0] a, input logic [63:0] b);
        bus.req_a[r*DW +: DW] = a;
        bus.req_b[r*DW +: DW] = b;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rsp_valid, bus.req_ready, bus.mul_ap_start} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ready=%b start=%b, want all 0",
                     bus.busy, bus.rsp_valid, bus.req_ready, bus.mul_ap_start);
        end
        checks++;
        if (bus.ops_count !== 32'd0 || bus.rsp_data !== 64'd0 || bus.mul_a !== 64'd0) begin
            errors++;
            $display("FAIL reset_regs: ops=%0d rsp_data=%h mul_a=%h, want 0",
                     bus.ops_count, bus.rsp_data, bus.mul_a);
        end
    endtask

    task automatic test_single();
        bit ok;
        core_lat = 1;
        set_ops(0, F_1, F_2);
        @(posedge clk); #1 bus.req_valid = 4'b0001;
        wait_req(ok);
        checks++;
        if (!ok || bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_accept: req_ready=%b ok=%0b, want 0001", bus.req_ready, ok);
        end
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp(ok);
        checks++;
        if (!ok || bus.rsp_valid !== 4'b0001 || bus.rsp_data !== F_2) begin
            errors++;
            $display("FAIL single_rsp: rsp_valid=%b data=%h, want 0001 %h", bus.rsp_valid, bus.rsp_data, F_2);
        end
        @(negedge clk);
        checks++;
        if (bus.ops_count !== 32'd1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_count: ops=%0d busy=%b, want 1 0", bus.ops_count, bus.busy);
        end
    endtask

    task automatic test_all_four();
        bit          ok;
        logic [3:0]  exp_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [63:0] exp_p  [4] = '{F_2, F_6, F_3, F_M2};
        do_reset();
        core_lat = 2;
        set_ops(0, F_1, F_2);
        set_ops(1, F_2, F_3);
        set_ops(2, F_1P5, F_2);
        set_ops(3, F_M1, F_2);
        @(posedge clk); #1 bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_req(ok);
            checks++;
            if (!ok || bus.req_ready !== exp_oh[k]) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b, want %b", k, bus.req_ready, exp_oh[k]);
            end
            if (k == 4) begin
                @(posedge clk); #1 bus.req_valid = '0;
            end
            wait_rsp(ok);
            checks++;
            if (!ok || bus.rsp_valid !== exp_oh[k] || bus.rsp_data !== exp_p[k % 4]) begin
                errors++;
                $display("FAIL rr_rsp%0d: rsp_valid=%b data=%h, want %b %h",
                         k, bus.rsp_valid, bus.rsp_data, exp_oh[k], exp_p[k % 4]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.ops_count !== 32'd5) begin
            errors++;
            $display("FAIL rr_count: ops=%0d, want 5", bus.ops_count);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        core_lat = 1;
        set_ops(1, F_2, F_3);
        bus.rsp_ready = 4'b1101;
        @(posedge clk); #1 bus.req_valid = 4'b0010;
        wait_req(ok);
        @(posedge clk); #1 bus.req_valid = 4'b0001;
        wait_rsp(ok);
        bad = ok ? 0 : 1;
        for (int n = 0; n < 10; n++) begin
            if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== F_6 ||
                bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
                bad++;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_rsp: rsp_valid=%b data=%h req_ready=%b busy=%b bad=%0d, want 0010 %h 0000 1",
                     bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.busy, bad, F_6);
        end
        bus.req_valid = '0;
        @(posedge clk); #1 bus.rsp_ready = 4'b1111;
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.ops_count !== 32'd6 || bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL hold_release: ops=%0d busy=%b rsp_valid=%b, want 6 0 0000",
                     bus.ops_count, bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_rotate();
        bit ok;
        core_lat = 1;
        set_ops(2, F_1P5, F_2);
        set_ops(3, F_M1, F_2);
        @(posedge clk); #1 bus.req_valid = 4'b0100;
        wait_req(ok);
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp(ok);
        @(posedge clk); #1 bus.req_valid = 4'b1100;
        wait_req(ok);
        checks++;
        if (!ok || bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rotate_first: req_ready=%b, want 1000", bus.req_ready);
        end
        @(posedge clk); #1 bus.req_valid = 4'b0100;
        wait_rsp(ok);
        checks++;
        if (!ok || bus.rsp_valid !== 4'b1000 || bus.rsp_data !== F_M2) begin
            errors++;
            $display("FAIL rotate_rsp3: rsp_valid=%b data=%h, want 1000 %h", bus.rsp_valid, bus.rsp_data, F_M2);
        end
        wait_req(ok);
        checks++;
        if (!ok || bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rotate_second: req_ready=%b, want 0100", bus.req_ready);
        end
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp(ok);
        checks++;
        if (!ok || bus.rsp_valid !== 4'b0100 || bus.rsp_data !== F_3) begin
            errors++;
            $display("FAIL rotate_rsp2: rsp_valid=%b data=%h, want 0100 %h", bus.rsp_valid, bus.rsp_data, F_3);
        end
    endtask

    task automatic test_zero_latency();
        bit ok;
        core_lat = 0;
        set_ops(0, F_1P5, F_2);
        @(posedge clk); #1 bus.req_valid = 4'b0001;
        wait_req(ok);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.mul_ap_start !== 1'b1 || bus.mul_a !== F_1P5 || bus.mul_b !== F_2) begin
            errors++;
            $display("FAIL zl_start: start=%b a=%h b=%h, want 1 %h %h", bus.mul_ap_start, bus.mul_a, bus.mul_b, F_1P5, F_2);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== F_3 || bus.mul_ap_start !== 1'b0) begin
            errors++;
            $display("FAIL zl_rsp: rsp_valid=%b data=%h start=%b, want 0001 %h 0",
                     bus.rsp_valid, bus.rsp_data, bus.mul_ap_start, F_3);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int late;
        core_lat = 5;
        set_ops(1, F_2, F_3);
        @(posedge clk); #1 bus.req_valid = 4'b0010;
        wait_req(ok);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.mul_ap_start !== 1'b0 || bus.ops_count === 32'd0) begin
            errors++;
            $display("FAIL rw_inwait: busy=%b start=%b ops=%0d, want 1 0 nonzero", bus.busy, bus.mul_ap_start, bus.ops_count);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.ops_count !== 32'd0) begin
            errors++;
            $display("FAIL rw_after: busy=%b rsp_valid=%b ops=%0d, want 0 0000 0", bus.busy, bus.rsp_valid, bus.ops_count);
        end
        late = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL rw_no_late: late response cycles=%0d, want 0", late);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        core_lat = 1;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = '1;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_rotate();
        test_zero_latency();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
